// File: rtl/memory_stream_writer.sv
// Streams upstream samples through a small FIFO into single-word memory writes,
// one frame of frame_len words per start, addresses wrapping within a fixed region.
module memory_stream_writer #(
    parameter logic [29:0] BASE_ADDR    = 30'h0000_0000,
    parameter int          REGION_WORDS = 1024,
    parameter int          FIFO_AW      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] frame_len,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] words_written,
    input  logic        mem_ready,
    output logic        mem_op,
    output logic        mem_rw,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_data
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int PTR_W = $clog2(REGION_WORDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        frame_len_q, frame_len_d;
    logic [15:0]        acc_cnt_q, acc_cnt_d;
    logic [15:0]        iss_cnt_q, iss_cnt_d;
    logic [15:0]        wr_cnt_q, wr_cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [29:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;

    logic [31:0]        fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               fifo_full, fifo_empty, push, pop;
    logic [29:0]        word_offset;

    assign fifo_full   = (count_q == (FIFO_AW+1)'(DEPTH));
    assign fifo_empty  = (count_q == '0);
    assign word_offset = 30'({ptr_q, 2'b00});

    assign busy          = (state_q == FETCH) || (state_q == ISSUE) || (state_q == WAIT);
    assign s_ready       = busy && !fifo_full && (acc_cnt_q < frame_len_q);
    assign push          = s_valid && s_ready;
    assign frame_done    = (state_q == DONE);
    assign mem_op        = (state_q == ISSUE);
    assign mem_rw        = 1'b0;
    assign mem_addr      = addr_q;
    assign mem_data      = data_q;
    assign words_written = wr_cnt_q;

    always_comb begin
        state_d     = state_q;
        frame_len_d = frame_len_q;
        acc_cnt_d   = acc_cnt_q;
        iss_cnt_d   = iss_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        ptr_d       = ptr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        pop         = 1'b0;

        if (push) begin
            acc_cnt_d = acc_cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    frame_len_d = frame_len;
                    acc_cnt_d   = '0;
                    iss_cnt_d   = '0;
                    wr_cnt_d    = '0;
                    ptr_d       = '0;
                    state_d     = (frame_len != 16'd0) ? FETCH : DONE;
                end
            end
            FETCH: begin
                if (!fifo_empty && mem_ready) begin
                    pop     = 1'b1;
                    data_d  = fifo_mem[rd_ptr_q];
                    addr_d  = BASE_ADDR + word_offset;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Power-of-two region: natural pointer overflow is the wrap.
                ptr_d     = ptr_q + PTR_W'(1);
                iss_cnt_d = iss_cnt_q + 16'd1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (mem_ready) begin
                    wr_cnt_d = wr_cnt_q + 16'd1;
                    state_d  = (iss_cnt_q == frame_len_q) ? DONE : FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            frame_len_q <= '0;
            acc_cnt_q   <= '0;
            iss_cnt_q   <= '0;
            wr_cnt_q    <= '0;
            ptr_q       <= '0;
            addr_q      <= BASE_ADDR;
            data_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            frame_len_q <= frame_len_d;
            acc_cnt_q   <= acc_cnt_d;
            iss_cnt_q   <= iss_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            ptr_q       <= ptr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            count_q     <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
        end
    end

    // Storage needs no reset: clearing the pointers and count empties the FIFO.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= s_data;
    end
endmodule

// File: tb/tb_memory_stream_writer.sv
// Bench for memory_stream_writer: a registered memory-controller model plus an
// address/data scoreboard filled on each accepted word and drained on each mem_op.
module tb_memory_stream_writer;
    localparam logic [29:0] BASE = 30'h0000_1000;
    localparam int          REGION = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] frame_len = '0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready, busy, frame_done, mem_op, mem_rw;
    logic [15:0] words_written;
    logic        mem_ready;
    logic [29:0] mem_addr;
    logic [31:0] mem_data;

    int checks = 0;
    int errors = 0;
    int ops = 0;
    int dones = 0;
    int acc_idx = 0;
    int lat = 4;
    logic hold = 1'b0;
    logic rdy_q;
    int   cnt_q;
    logic [61:0] exp_q[$];

    memory_stream_writer #(
        .BASE_ADDR(BASE), .REGION_WORDS(REGION), .FIFO_AW(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .busy(busy),
        .frame_done(frame_done), .words_written(words_written),
        .mem_ready(mem_ready), .mem_op(mem_op), .mem_rw(mem_rw),
        .mem_addr(mem_addr), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    // Controller model: drops ready the cycle after a request, recovers after lat cycles.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_q <= 1'b1;
            cnt_q <= 0;
        end else if (mem_op) begin
            rdy_q <= 1'b0;
            cnt_q <= lat;
        end else if (cnt_q > 1) begin
            cnt_q <= cnt_q - 1;
        end else if (cnt_q == 1) begin
            cnt_q <= 0;
            rdy_q <= 1'b1;
        end
    end
    assign mem_ready = rdy_q && !hold;

    always @(negedge clk) begin
        if (mem_op) begin
            ops++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_op got addr=%h data=%h, expected no request", mem_addr, mem_data);
            end else begin
                logic [61:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_data} !== e || mem_rw !== 1'b0) begin
                    errors++;
                    $display("FAIL sb_write got addr=%h data=%h rw=%b, expected addr=%h data=%h rw=0",
                             mem_addr, mem_data, mem_rw, e[61:32], e[31:0]);
                end
            end
        end
        if (frame_done) dones++;
    end

    task automatic sb_push(input logic [31:0] d);
        logic [29:0] a;
        a = BASE + 30'((acc_idx % REGION) * 4);
        exp_q.push_back({a, d});
        acc_idx++;
    endtask

    task automatic do_start(input logic [15:0] n);
        @(negedge clk);
        start = 1'b1;
        frame_len = n;
        @(posedge clk);
        #1;
        start = 1'b0;
        acc_idx = 0;
    endtask

    task automatic offer(input int n, input logic [31:0] d0);
        for (int i = 0; i < n; i++) begin
            int guard;
            s_data = d0 + 32'(i);
            s_valid = 1'b1;
            guard = 0;
            @(negedge clk);
            while (!s_ready && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            if (!s_ready) begin
                checks++;
                errors++;
                $display("FAIL offer_timeout word %0d got s_ready=0, expected 1", i);
                break;
            end
            sb_push(s_data);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        @(negedge clk);
        while (!frame_done && c < 1000) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (!frame_done) begin
            errors++;
            $display("FAIL done_timeout got frame_done=0, expected 1");
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (mem_op !== 1'b0 || mem_rw !== 1'b0 || mem_addr !== BASE || mem_data !== 32'h0 ||
            s_ready !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || words_written !== 16'h0) begin
            errors++;
            $display("FAIL %s got op=%b rw=%b addr=%h data=%h rdy=%b busy=%b done=%b ww=%0d, expected reset values",
                     tag, mem_op, mem_rw, mem_addr, mem_data, s_ready, busy, frame_done, words_written);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_asserted");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_released");
    endtask

    task automatic test_basic();
        int o0, d0;
        lat = 4;
        o0 = ops;
        d0 = dones;
        do_start(3);
        offer(3, 32'hA0);
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_sready_after_last got %b, expected 0", s_ready);
        end
        wait_done();
        @(negedge clk);
        checks++;
        if (words_written !== 16'd3 || ops - o0 != 3 || dones - d0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_totals got ww=%0d ops=%0d dones=%0d left=%0d, expected 3 3 1 0",
                     words_written, ops - o0, dones - d0, exp_q.size());
        end
    endtask

    task automatic test_latency();
        lat = 1;
        do_start(1);
        s_data = 32'h5A5A_0001;
        s_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL latency_ready got %b, expected 1", s_ready);
        end
        sb_push(s_data);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_op !== 1'b0) begin
            errors++;
            $display("FAIL latency_early_op got %b, expected 0", mem_op);
        end
        @(negedge clk);
        checks++;
        if (mem_op !== 1'b1) begin
            errors++;
            $display("FAIL latency_op got %b, expected 1", mem_op);
        end
        wait_done();
    endtask

    task automatic test_wrap();
        lat = 1;
        do_start(6);
        offer(6, 32'hB000_0000);
        wait_done();
        @(negedge clk);
        checks++;
        if (words_written !== 16'd6 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_totals got ww=%0d left=%0d, expected 6 0", words_written, exp_q.size());
        end
    endtask

    task automatic test_back_pressure();
        int accepted;
        lat = 2;
        hold = 1'b1;
        accepted = 0;
        do_start(10);
        s_valid = 1'b1;
        s_data = 32'hC000_0000;
        for (int c = 0; c < 50; c++) begin
            logic took;
            @(negedge clk);
            took = s_ready;
            if (took) sb_push(s_data);
            @(posedge clk);
            #1;
            if (took) begin
                accepted++;
                s_data = s_data + 32'd1;
            end
        end
        s_valid = 1'b0;
        checks++;
        if (accepted != 4 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_fifo_full got accepted=%0d s_ready=%b, expected 4 0", accepted, s_ready);
        end
        hold = 1'b0;
        offer(6, 32'hC000_0004);
        wait_done();
        @(negedge clk);
        checks++;
        if (words_written !== 16'd10 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_totals got ww=%0d left=%0d, expected 10 0", words_written, exp_q.size());
        end
    endtask

    task automatic test_zero_len();
        int o0;
        logic seen;
        o0 = ops;
        seen = 1'b0;
        do_start(0);
        for (int c = 0; c < 2 && !seen; c++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        checks++;
        if (!seen || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done got seen=%b busy=%b, expected 1 0", seen, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (ops != o0 || words_written !== 16'd0) begin
            errors++;
            $display("FAIL zero_totals got ops=%0d ww=%0d, expected 0 0", ops - o0, words_written);
        end
    endtask

    task automatic test_start_ignored();
        int o0;
        lat = 2;
        o0 = ops;
        do_start(3);
        offer(1, 32'hD0);
        @(negedge clk);
        start = 1'b1;
        frame_len = 16'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        offer(2, 32'hD1);
        wait_done();
        repeat (3) @(negedge clk);
        checks++;
        if (words_written !== 16'd3 || ops - o0 != 3 || busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL restart_ignored got ww=%0d ops=%0d busy=%b left=%0d, expected 3 3 0 0",
                     words_written, ops - o0, busy, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int o0, c;
        lat = 6;
        o0 = ops;
        do_start(5);
        offer(3, 32'hE0);
        c = 0;
        while (ops - o0 < 3 && c < 200) begin
            @(negedge clk);
            #1;
            c++;
        end
        checks++;
        if (ops - o0 != 3 || words_written !== 16'd2) begin
            errors++;
            $display("FAIL midreset_setup got ops=%0d ww=%0d, expected 3 2", ops - o0, words_written);
        end
        reset = 1'b1;
        #1;
        check_idle_outputs("midreset_async");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        o0 = ops;
        repeat (20) @(negedge clk);
        checks++;
        if (ops != o0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet got ops=%0d busy=%b, expected 0 0", ops - o0, busy);
        end
        lat = 2;
        do_start(1);
        offer(1, 32'hF00D);
        wait_done();
        @(negedge clk);
        checks++;
        if (words_written !== 16'd1 || mem_addr !== BASE || mem_data !== 32'hF00D) begin
            errors++;
            $display("FAIL midreset_restart got ww=%0d addr=%h data=%h, expected 1 %h 0000f00d",
                     words_written, mem_addr, mem_data, BASE);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_wrap();
        test_back_pressure();
        test_zero_len();
        test_start_ignored();
        test_reset_mid();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
